// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NQ_DEF = 16;
  localparam int NB_DEF = 8;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: bring in the next dividend bit and
// subtract the divisor when it fits, yielding the next remainder and quotient bit.
module div_step #(
  parameter int NB = 8
) (
  input  logic [NB-1:0] rem_i,
  input  logic          bit_i,
  input  logic [NB-1:0] div_i,
  output logic [NB-1:0] rem_o,
  output logic          q_o
);

  logic [NB:0] shifted;
  logic [NB:0] diff;

  // Keep the shifted remainder one bit wider so its MSB is never dropped.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, div_i};
    q_o     = (shifted >= {1'b0, div_i});
    rem_o   = q_o ? diff[NB-1:0] : shifted[NB-1:0];
  end

endmodule

// File: rtl/div16u8_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready at both ends.
// Optional DIV_APPROX_EN: divides floor(A/4) in NQ-2 steps and scales the quotient by 4.
module div16u8_seq
  import div_pkg::*;
#(
  parameter int NQ = NQ_DEF,
  parameter int NB = NB_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NQ-1:0] A,
  input  logic [NB-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NQ-1:0] Q,
  output logic [NB-1:0] R,
  output logic          div0
);

  localparam int CW = $clog2(NQ + 1);
`ifdef DIV_APPROX_EN
  localparam logic [CW-1:0] NITER = CW'(NQ - 2);
`else
  localparam logic [CW-1:0] NITER = CW'(NQ);
`endif

  state_e          state_q, state_d;
  logic [NQ-1:0]   a_q, a_d;
  logic [NB-1:0]   b_q, b_d;
  logic [NB-1:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NQ-1:0]   q_q, q_d;
  logic [NB-1:0]   r_q, r_d;
  logic            div0_q, div0_d;

  logic [NB-1:0]   step_rem;
  logic            step_q;

  div_step #(.NB(NB)) u_step (
    .rem_i (rem_q),
    .bit_i (a_q[NQ-1]),
    .div_i (b_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // a_q doubles as dividend shifter and quotient accumulator.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
`ifdef DIV_APPROX_EN
          if (B != '0) a_d = {A[NQ-1:2], 2'b00};
`endif
          b_d     = B;
          rem_d   = '0;
          cnt_d   = NITER;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (b_q == '0) begin
          q_d     = '1;
          r_d     = a_q[NB-1:0];
          div0_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == '0) begin
`ifdef DIV_APPROX_EN
          q_d     = {a_q[NQ-3:0], 2'b00};
`else
          q_d     = a_q;
`endif
          r_d     = rem_q;
          div0_d  = 1'b0;
          state_d = DONE;
        end else begin
          a_d   = {a_q[NQ-2:0], step_q};
          rem_d = step_rem;
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_div16u8_seq.sv
// Scoreboard bench for div16u8_seq: arithmetic reference model, directed corners
// plus randomized operands and output stalls.
module tb_div16u8_seq;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        d0;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        div0;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t exp_q[$];
  bit   rand_phase = 1'b0;

  always #5 clk = ~clk;

  div16u8_seq #(.NQ(16), .NB(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .div0(div0)
  );

  function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
    res_t   res;
    int     a4;
    if (b == 0) begin
      res.q = 16'hFFFF; res.r = a[7:0]; res.d0 = 1'b1;
    end else begin
`ifdef DIV_APPROX_EN
      a4 = int'(a) / 4;
      res.q = 16'(4 * (a4 / int'(b)));
      res.r = 8'(a4 % int'(b));
`else
      res.q = 16'(int'(a) / int'(b));
      res.r = 8'(int'(a) % int'(b));
`endif
      res.d0 = 1'b0;
    end
    return res;
  endfunction

  function automatic int model_lat(input logic [7:0] b);
    if (b == 0) return 1;
`ifdef DIV_APPROX_EN
    return 15;
`else
    return 17;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per completed output handshake.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("Q", 32'(Q), 32'(e.q));
          check("R", 32'(R), 32'(e.r));
          check("div0", 32'(div0), 32'(e.d0));
        end
      end
    end
  end

  // Random consumer backpressure during the random phase only.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Waits for in_ready, performs the accept edge, optionally scores the result.
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit push);
    int n;
    A = a; B = b; in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'(in_ready), 32'(1));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back(model(a, b));
  endtask

  // Counts edges after the accept edge until out_valid appears.
  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
      if (n > 60) break;
    end
    check("latency", 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    bit   seen;
    logic [15:0] ra;
    logic [7:0]  rb;

    // Reset state, sampled while rst is still high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_Q", 32'(Q), 32'(0));
    check("rst_R", 32'(R), 32'(0));
    check("rst_div0", 32'(div0), 32'(0));
    rst = 1'b0;

    // Basic, divide-by-zero and corner operands.
    issue(16'd1000, 8'd7, 1'b1);   wait_done(model_lat(8'd7));
    issue(16'h1234, 8'd0, 1'b1);   wait_done(model_lat(8'd0));
    issue(16'hFFFF, 8'd1, 1'b1);   wait_done(model_lat(8'd1));
    issue(16'd5, 8'd200, 1'b1);    wait_done(model_lat(8'd200));
    issue(16'hFFFF, 8'd255, 1'b1); wait_done(model_lat(8'd255));

    // Output stall for 10 cycles, then release with the next request pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(16'd1000, 8'd7, 1'b1);
    wait_done(model_lat(8'd7));
    e = model(16'd1000, 8'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'(1));
      check("stall_Q", 32'(Q), 32'(e.q));
      check("stall_R", 32'(R), 32'(e.r));
    end
    out_ready = 1'b1;
    A = 16'd60000; B = 8'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(in_ready), 32'(1));
    check("release_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    check("b2b_accepted", 32'(in_ready), 32'(0));
    in_valid = 1'b0;
    exp_q.push_back(model(16'd60000, 8'd13));
    wait_done(model_lat(8'd13));

    // Reset mid-operation: result discarded, no out_valid afterwards.
    @(posedge clk); #1;
    issue(16'd40000, 8'd3, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'(0));
    check("abort_idle_ready", 32'(in_ready), 32'(1));

    // Randomized operands with random consumer backpressure.
    rand_phase = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom());
      case ($urandom_range(0, 4))
        0: rb = 8'd0;
        1: rb = 8'($urandom_range(1, 3));
        default: rb = 8'($urandom());
      endcase
      issue(ra, rb, 1'b1);
      wait_done(model_lat(rb));
    end
    rand_phase = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
